// File: rtl/coprocessor0_params.sv
// rtl/coprocessor0_params.sv - CP0 exception codes, vector default and CP0-to-fetch bus
package coprocessor0_params;

  localparam logic [31:0] EXCEPTION_VECTOR_DEFAULT = 32'hbfc00380;

  typedef enum logic [4:0] {
    EXC_INT  = 5'h00,
    EXC_ADEL = 5'h04,
    EXC_ADES = 5'h05,
    EXC_SYS  = 5'h08,
    EXC_BP   = 5'h09,
    EXC_RI   = 5'h0a,
    EXC_OV   = 5'h0c
  } exception_code_t;

  typedef struct packed {
    logic [31:0] exception_address;
    logic [7:0]  interrupt_valid;
  } cp0_to_if_bus_t;

endpackage

// File: rtl/wb_stage_params.sv
// rtl/wb_stage_params.sv - writeback-to-CP0 write/exception bus
package wb_stage_params;
  import coprocessor0_params::*;

  typedef struct packed {
    logic            exception_valid;
    exception_code_t exception_code;
    logic [31:0]     exception_address;
    logic            in_delay_slot;
    logic            is_address_fault;
    logic [31:0]     badvaddr_value;
    logic            eret_flush;
    logic            write_enabled;
    logic [4:0]      address_register;
    logic [2:0]      address_select;
    logic [31:0]     write_data;
  } wb_to_cp0_bus_t;

endpackage

// File: rtl/exception_priority_encoder.sv
// rtl/exception_priority_encoder.sv - picks the winning exception source of a retiring instruction
module exception_priority_encoder
  import coprocessor0_params::*;
(
  input  logic            interrupt_pending,
  input  logic            fetch_address_error,
  input  logic            reserved_instruction,
  input  logic            overflow,
  input  logic            syscall,
  input  logic            break_point,
  input  logic            load_address_error,
  input  logic            store_address_error,
  output logic            exception_valid,
  output exception_code_t exception_code,
  output logic            is_address_fault
);

  always_comb begin
    exception_valid  = 1'b1;
    exception_code   = EXC_INT;
    is_address_fault = 1'b0;
    if (interrupt_pending) begin
      exception_code = EXC_INT;
    end else if (fetch_address_error) begin
      exception_code   = EXC_ADEL;
      is_address_fault = 1'b1;
    end else if (reserved_instruction) begin
      exception_code = EXC_RI;
    end else if (overflow) begin
      exception_code = EXC_OV;
    end else if (syscall) begin
      exception_code = EXC_SYS;
    end else if (break_point) begin
      exception_code = EXC_BP;
    end else if (load_address_error) begin
      exception_code   = EXC_ADEL;
      is_address_fault = 1'b1;
    end else if (store_address_error) begin
      exception_code   = EXC_ADES;
      is_address_fault = 1'b1;
    end else begin
      exception_valid = 1'b0;
    end
  end

endmodule

// File: rtl/exception_dispatcher.sv
// rtl/exception_dispatcher.sv - writeback exception/ERET dispatcher; EXCEPTION_DISPATCHER_INTERRUPT_EN enables interrupts
module exception_dispatcher
  import coprocessor0_params::*;
  import wb_stage_params::*;
#(
  parameter logic [31:0] EXCEPTION_VECTOR = EXCEPTION_VECTOR_DEFAULT
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           wb_valid,
  output logic           wb_ready,
  input  logic [31:0]    wb_pc,
  input  logic           wb_in_delay_slot,
  input  logic           wb_fetch_address_error,
  input  logic           wb_reserved_instruction,
  input  logic           wb_overflow,
  input  logic           wb_syscall,
  input  logic           wb_break,
  input  logic           wb_load_address_error,
  input  logic           wb_store_address_error,
  input  logic [31:0]    wb_data_address,
  input  logic           wb_is_eret,
  input  logic           wb_is_mtc0,
  input  logic [4:0]     wb_cp0_register,
  input  logic [2:0]     wb_cp0_select,
  input  logic [31:0]    wb_cp0_write_data,
  input  cp0_to_if_bus_t cp0_to_if_data_bus,
  output wb_to_cp0_bus_t wb_to_cp0_data_bus,
  output logic           pipeline_flush,
  output logic           redirect_valid,
  output logic [31:0]    redirect_address,
  input  logic           redirect_ready
);

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            pipeline_flush_q, pipeline_flush_d;
  logic [31:0]     redirect_address_q, redirect_address_d;
  logic            interrupt_pending_q, interrupt_pending_d;
  logic            commit;
  logic            exc_valid;
  exception_code_t exc_code;
  logic            exc_fault;

`ifdef EXCEPTION_DISPATCHER_INTERRUPT_EN
  always_comb interrupt_pending_d = |cp0_to_if_data_bus.interrupt_valid;
`else
  logic unused_interrupt_valid;
  assign unused_interrupt_valid = ^cp0_to_if_data_bus.interrupt_valid;
  always_comb interrupt_pending_d = 1'b0;
`endif

  exception_priority_encoder u_priority (
    .interrupt_pending   (interrupt_pending_q),
    .fetch_address_error (wb_fetch_address_error),
    .reserved_instruction(wb_reserved_instruction),
    .overflow            (wb_overflow),
    .syscall             (wb_syscall),
    .break_point         (wb_break),
    .load_address_error  (wb_load_address_error),
    .store_address_error (wb_store_address_error),
    .exception_valid     (exc_valid),
    .exception_code      (exc_code),
    .is_address_fault    (exc_fault)
  );

  assign wb_ready         = (state_q == ST_IDLE);
  assign redirect_valid   = (state_q == ST_REDIRECT);
  assign pipeline_flush   = pipeline_flush_q;
  assign redirect_address = redirect_address_q;
  assign commit           = wb_valid && wb_ready;

  // Exception and write fields are only populated when they take effect.
  always_comb begin
    wb_to_cp0_data_bus = '0;
    if (commit) begin
      wb_to_cp0_data_bus.exception_valid = exc_valid;
      if (exc_valid) begin
        wb_to_cp0_data_bus.exception_code    = exc_code;
        wb_to_cp0_data_bus.exception_address = wb_pc;
        wb_to_cp0_data_bus.in_delay_slot     = wb_in_delay_slot;
        wb_to_cp0_data_bus.is_address_fault  = exc_fault;
        if (exc_fault) begin
          wb_to_cp0_data_bus.badvaddr_value =
            wb_fetch_address_error ? wb_pc : wb_data_address;
        end
      end
      wb_to_cp0_data_bus.eret_flush = wb_is_eret && !exc_valid;
      if (wb_is_mtc0 && !exc_valid) begin
        wb_to_cp0_data_bus.write_enabled    = 1'b1;
        wb_to_cp0_data_bus.address_register = wb_cp0_register;
        wb_to_cp0_data_bus.address_select   = wb_cp0_select;
        wb_to_cp0_data_bus.write_data       = wb_cp0_write_data;
      end
    end
  end

  always_comb begin
    state_d            = state_q;
    pipeline_flush_d   = 1'b0;
    redirect_address_d = redirect_address_q;
    case (state_q)
      ST_IDLE: begin
        if (commit && exc_valid) begin
          state_d            = ST_REDIRECT;
          pipeline_flush_d   = 1'b1;
          redirect_address_d = EXCEPTION_VECTOR;
        end else if (commit && wb_is_eret) begin
          state_d            = ST_REDIRECT;
          pipeline_flush_d   = 1'b1;
          redirect_address_d = cp0_to_if_data_bus.exception_address;
        end
      end
      ST_REDIRECT: begin
        if (redirect_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q             <= ST_IDLE;
      pipeline_flush_q    <= 1'b0;
      redirect_address_q  <= 32'h0;
      interrupt_pending_q <= 1'b0;
    end else begin
      state_q             <= state_d;
      pipeline_flush_q    <= pipeline_flush_d;
      redirect_address_q  <= redirect_address_d;
      interrupt_pending_q <= interrupt_pending_d;
    end
  end

endmodule

// File: tb/tb_exception_dispatcher.sv
// tb/tb_exception_dispatcher.sv - directed plus random checks of exception_dispatcher against a reference model
module tb_exception_dispatcher;
  import coprocessor0_params::*;
  import wb_stage_params::*;

  localparam logic [31:0] VEC = 32'hbfc00380;

  logic           clock = 1'b0;
  logic           reset;
  logic           wb_valid;
  logic           wb_ready;
  logic [31:0]    wb_pc;
  logic           wb_in_delay_slot;
  logic           wb_fetch_address_error;
  logic           wb_reserved_instruction;
  logic           wb_overflow;
  logic           wb_syscall;
  logic           wb_break;
  logic           wb_load_address_error;
  logic           wb_store_address_error;
  logic [31:0]    wb_data_address;
  logic           wb_is_eret;
  logic           wb_is_mtc0;
  logic [4:0]     wb_cp0_register;
  logic [2:0]     wb_cp0_select;
  logic [31:0]    wb_cp0_write_data;
  cp0_to_if_bus_t cp0_to_if_data_bus;
  wb_to_cp0_bus_t wb_to_cp0_data_bus;
  logic           pipeline_flush;
  logic           redirect_valid;
  logic [31:0]    redirect_address;
  logic           redirect_ready;

  exception_dispatcher dut (
    .clock                  (clock),
    .reset                  (reset),
    .wb_valid               (wb_valid),
    .wb_ready               (wb_ready),
    .wb_pc                  (wb_pc),
    .wb_in_delay_slot       (wb_in_delay_slot),
    .wb_fetch_address_error (wb_fetch_address_error),
    .wb_reserved_instruction(wb_reserved_instruction),
    .wb_overflow            (wb_overflow),
    .wb_syscall             (wb_syscall),
    .wb_break               (wb_break),
    .wb_load_address_error  (wb_load_address_error),
    .wb_store_address_error (wb_store_address_error),
    .wb_data_address        (wb_data_address),
    .wb_is_eret             (wb_is_eret),
    .wb_is_mtc0             (wb_is_mtc0),
    .wb_cp0_register        (wb_cp0_register),
    .wb_cp0_select          (wb_cp0_select),
    .wb_cp0_write_data      (wb_cp0_write_data),
    .cp0_to_if_data_bus     (cp0_to_if_data_bus),
    .wb_to_cp0_data_bus     (wb_to_cp0_data_bus),
    .pipeline_flush         (pipeline_flush),
    .redirect_valid         (redirect_valid),
    .redirect_address       (redirect_address),
    .redirect_ready         (redirect_ready)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Reference model: one bit of "waiting for fetch", plus flush/target/interrupt memory.
  bit             m_redirect;
  bit             m_flush;
  logic [31:0]    m_addr;
  bit             m_int;
  bit             exp_commit;
  bit             exp_exc;
  wb_to_cp0_bus_t exp_bus;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compute_expected();
    bit         flags[8];
    logic [4:0] codes[8];
    int         win;
    flags = '{m_int, wb_fetch_address_error, wb_reserved_instruction, wb_overflow,
              wb_syscall, wb_break, wb_load_address_error, wb_store_address_error};
    codes = '{5'h00, 5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09, 5'h04, 5'h05};
    exp_bus    = '0;
    exp_commit = wb_valid && !m_redirect;
    exp_exc    = 1'b0;
    win        = -1;
    if (exp_commit) begin
      for (int i = 0; i < 8; i++) if (flags[i] && win < 0) win = i;
      exp_exc = (win >= 0);
      exp_bus.exception_valid = exp_exc;
      if (exp_exc) begin
        exp_bus.exception_code    = exception_code_t'(codes[win]);
        exp_bus.exception_address = wb_pc;
        exp_bus.in_delay_slot     = wb_in_delay_slot;
        exp_bus.is_address_fault  = (codes[win] == 5'h04 || codes[win] == 5'h05);
        exp_bus.badvaddr_value    = (win == 1) ? wb_pc : (win >= 6) ? wb_data_address : 32'h0;
      end
      exp_bus.eret_flush = wb_is_eret && !exp_exc;
      if (wb_is_mtc0 && !exp_exc) begin
        exp_bus.write_enabled    = 1'b1;
        exp_bus.address_register = wb_cp0_register;
        exp_bus.address_select   = wb_cp0_select;
        exp_bus.write_data       = wb_cp0_write_data;
      end
    end
  endtask

  task automatic update_model();
    if (reset) begin
      m_redirect = 1'b0;
      m_flush    = 1'b0;
      m_addr     = 32'h0;
      m_int      = 1'b0;
    end else begin
      m_flush = 1'b0;
      if (m_redirect) begin
        if (redirect_ready) m_redirect = 1'b0;
      end else if (exp_commit && (exp_exc || wb_is_eret)) begin
        m_redirect = 1'b1;
        m_flush    = 1'b1;
        m_addr     = exp_exc ? VEC : cp0_to_if_data_bus.exception_address;
      end
`ifdef EXCEPTION_DISPATCHER_INTERRUPT_EN
      m_int = |cp0_to_if_data_bus.interrupt_valid;
`else
      m_int = 1'b0;
`endif
    end
  endtask

  task automatic step();
    @(negedge clock);
    compute_expected();
    chk("wb_ready", wb_ready, !m_redirect);
    chk("redirect_valid", redirect_valid, m_redirect);
    chk("pipeline_flush", pipeline_flush, m_flush);
    chk("redirect_address", redirect_address, m_addr);
    chk("bus", wb_to_cp0_data_bus, exp_bus);
    @(posedge clock);
    update_model();
    #1;
  endtask

  task automatic clear_instr();
    wb_valid = 0; wb_pc = 32'h0; wb_in_delay_slot = 0;
    wb_fetch_address_error = 0; wb_reserved_instruction = 0; wb_overflow = 0;
    wb_syscall = 0; wb_break = 0; wb_load_address_error = 0; wb_store_address_error = 0;
    wb_data_address = 32'h0; wb_is_eret = 0; wb_is_mtc0 = 0;
    wb_cp0_register = 5'h0; wb_cp0_select = 3'h0; wb_cp0_write_data = 32'h0;
  endtask

  initial begin
    clear_instr();
    reset = 1'b1;
    redirect_ready = 1'b0;
    cp0_to_if_data_bus = '0;
    repeat (2) @(posedge clock);
    m_redirect = 0; m_flush = 0; m_addr = 32'h0; m_int = 0;
    #1 reset = 1'b0;
    step();

    // Plain ALU commit
    wb_valid = 1; wb_pc = 32'hbfc00100; wb_data_address = 32'h1234;
    #1 chk("alu_bus_zero", wb_to_cp0_data_bus, '0);
    step();
    clear_instr(); step();

    // Overflow in delay slot, fetch stalls three cycles
    wb_valid = 1; wb_pc = 32'hbfc00200; wb_in_delay_slot = 1; wb_overflow = 1;
    #1 chk("ov_code", wb_to_cp0_data_bus.exception_code, 5'h0c);
    chk("ov_epc", wb_to_cp0_data_bus.exception_address, 32'hbfc00200);
    chk("ov_ds", wb_to_cp0_data_bus.in_delay_slot, 1'b1);
    step();
    clear_instr();
    chk("ov_flush", pipeline_flush, 1'b1);
    chk("ov_vector", redirect_address, 32'hbfc00380);
    repeat (3) step();
    redirect_ready = 1; step();
    redirect_ready = 0; step();

    // AdES store, ready held high in advance
    redirect_ready = 1;
    wb_valid = 1; wb_pc = 32'hbfc00300; wb_store_address_error = 1; wb_data_address = 32'h80000003;
    #1 chk("ades_code", wb_to_cp0_data_bus.exception_code, 5'h05);
    chk("ades_badvaddr", wb_to_cp0_data_bus.badvaddr_value, 32'h80000003);
    chk("ades_fault", wb_to_cp0_data_bus.is_address_fault, 1'b1);
    step();
    clear_instr(); step(); step();

    // Interrupt pending while ERET retires
    cp0_to_if_data_bus.exception_address = 32'hbfc00500;
    cp0_to_if_data_bus.interrupt_valid = 8'h80;
    step();
    wb_valid = 1; wb_pc = 32'hbfc00600; wb_is_eret = 1;
    step();
    clear_instr(); cp0_to_if_data_bus.interrupt_valid = 8'h00;
`ifdef EXCEPTION_DISPATCHER_INTERRUPT_EN
    chk("int_redirect", redirect_address, 32'hbfc00380);
`else
    chk("eret_redirect", redirect_address, 32'hbfc00500);
`endif
    step(); step();

    // MTC0 EPC then ERET
    wb_valid = 1; wb_pc = 32'hbfc00700; wb_is_mtc0 = 1;
    wb_cp0_register = 5'd14; wb_cp0_select = 3'd0; wb_cp0_write_data = 32'hbfc00400;
    #1 chk("mtc0_we", wb_to_cp0_data_bus.write_enabled, 1'b1);
    step();
    clear_instr(); cp0_to_if_data_bus.exception_address = 32'hbfc00400;
    wb_valid = 1; wb_pc = 32'hbfc00704; wb_is_eret = 1;
    #1 chk("eret_flush", wb_to_cp0_data_bus.eret_flush, 1'b1);
    step();
    clear_instr();
    chk("eret_target", redirect_address, 32'hbfc00400);
    step(); step();

    // Reset while in REDIRECT
    redirect_ready = 0;
    wb_valid = 1; wb_pc = 32'hbfc00800; wb_syscall = 1;
    step();
    clear_instr(); reset = 1; step();
    reset = 0;
    chk("rst_rv", redirect_valid, 1'b0);
    chk("rst_ready", wb_ready, 1'b1);
    chk("rst_flush", pipeline_flush, 1'b0);
    step();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(99) == 0);
      wb_valid = !reset && ($urandom_range(9) < 7);
      wb_pc = $urandom; wb_in_delay_slot = $urandom_range(1);
      wb_fetch_address_error  = ($urandom_range(11) == 0);
      wb_reserved_instruction = ($urandom_range(11) == 0);
      wb_overflow             = ($urandom_range(11) == 0);
      wb_syscall              = ($urandom_range(11) == 0);
      wb_break                = ($urandom_range(11) == 0);
      wb_load_address_error   = ($urandom_range(11) == 0);
      wb_store_address_error  = ($urandom_range(11) == 0);
      wb_data_address = $urandom;
      wb_is_eret = ($urandom_range(5) == 0);
      wb_is_mtc0 = ($urandom_range(3) == 0);
      wb_cp0_register = 5'($urandom); wb_cp0_select = 3'($urandom);
      wb_cp0_write_data = $urandom;
      cp0_to_if_data_bus.exception_address = $urandom;
      cp0_to_if_data_bus.interrupt_valid = ($urandom_range(7) == 0) ? 8'($urandom_range(255, 1)) : 8'h00;
      redirect_ready = $urandom_range(1);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exception_dispatcher.md
# exception_dispatcher

Writeback-stage exception and redirect controller: the producer side of the CP0 write/exception bus and the consumer of the CP0-to-fetch bus. It prioritizes the retiring instruction's exception flags against pending interrupts and drives `wb_to_cp0_bus_t` (MTC0 writes, exception capture, ERET). It issues a one-cycle pipeline flush and holds a fetch redirect (exception vector or EPC) under a valid/ready handshake until the fetch stage accepts it.

## Interface
- `EXCEPTION_VECTOR`, default 32'hbfc00380: redirect target for every exception; BEV is fixed at 1.
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `wb_valid`  in  1: the retiring instruction is present.
- `wb_ready`  out  1: high only in IDLE; `wb_valid && wb_ready` is a commit.
- `wb_pc`  in  32: PC of the retiring instruction.
- `wb_in_delay_slot`  in  1: the instruction sits in a branch delay slot.
- `wb_fetch_address_error`, `wb_reserved_instruction`, `wb_overflow`, `wb_syscall`, `wb_break`, `wb_load_address_error`, `wb_store_address_error`  in  1 each: raw exception flags.
- `wb_data_address`  in  32: effective address of the load or store.
- `wb_is_eret`, `wb_is_mtc0`  in  1 each: instruction class.
- `wb_cp0_register`  in  5; `wb_cp0_select`  in  3; `wb_cp0_write_data`  in  32: MTC0 target and data.
- `cp0_to_if_data_bus`  in  `cp0_to_if_bus_t`: EPC (`exception_address`) and `interrupt_valid[7:0]`.
- `wb_to_cp0_data_bus`  out  `wb_to_cp0_bus_t`: combinational from the committing instruction.
- `pipeline_flush`  out  1: one-cycle kill of all younger stages.
- `redirect_valid`  out  1; `redirect_address`  out  32; `redirect_ready`  in  1: fetch redirect handshake.

## Operation
- Interrupt sampling: `interrupt_pending_q <= |interrupt_valid` every cycle; reset value 0.
- An interrupt is taken only by a committing instruction while `interrupt_pending_q` is 1. EPC is that instruction's PC.
- Priority, highest first:
  - Int 0x00
  - fetch AdEL 0x04
  - RI 0x0a
  - Ov 0x0c
  - Sys 0x08
  - Bp 0x09
  - data AdEL 0x04
  - AdES 0x05
- Bus fields are driven only on a commit:
  - `exception_valid`: set when any source is taken.
  - `exception_code`: the code of the winning source.
  - `exception_address`: `wb_pc`, raw. CP0 applies the delay-slot −4 itself.
  - `in_delay_slot`: `wb_in_delay_slot`.
  - `is_address_fault`: set for codes 0x04 and 0x05.
  - `badvaddr_value`: `wb_pc` for a fetch AdEL, `wb_data_address` for a data AdEL or AdES.
  - `eret_flush`: `wb_is_eret && !exception_valid`.
  - `write_enabled`: `wb_is_mtc0 && !exception_valid`, with `address_register`, `address_select` and `write_data` passed through.
- Outside a commit every bus field is 0.
- States:
  - IDLE: a commit with an exception latches `EXCEPTION_VECTOR` and moves to REDIRECT. A commit with ERET (and no exception) latches `cp0_to_if_data_bus.exception_address` and moves to REDIRECT. Any other commit stays in IDLE.
  - REDIRECT: `redirect_valid` = 1, `wb_ready` = 0. When `redirect_ready` is sampled at 1, return to IDLE.
- `pipeline_flush` is 1 exactly in the first REDIRECT cycle.

## Timing
- Commit in cycle N:
  - CP0 sees the bus in cycle N and updates at the end of N.
  - In N+1: `pipeline_flush` = 1, `redirect_valid` = 1, and `redirect_address` is stable until handshake.
- Handshake completes at the edge where `redirect_valid && redirect_ready`. The state is IDLE and `wb_ready` = 1 the next cycle. Minimum exception-to-next-commit spacing is 2 cycles.
- `redirect_ready` held high in advance completes the handshake in N+1.
- EXL is set at the end of N, so `interrupt_pending_q` is 0 from N+2. No back-to-back interrupt.
- Interrupt plus ERET on the same instruction: the interrupt wins and `eret_flush` = 0. Interrupt plus MTC0: the write is suppressed.
- MTC0 EPC immediately followed by ERET: ERET redirects to the new EPC, because the write landed at the previous edge.
- Reset in any state:
  - Next cycle is IDLE.
  - `redirect_valid`, `pipeline_flush`, `interrupt_pending_q` and `redirect_address` are 0.
  - `wb_ready` is 1.
  - The bus is all 0.

## Configuration
- `EXCEPTION_DISPATCHER_INTERRUPT_EN` defined: interrupt sampling and code 0x00 are compiled in.
- Undefined: `interrupt_pending_q` is tied to 0, `interrupt_valid` is ignored, and code 0x00 is never generated. All other behaviour is identical.

## Structure
- Exception-code enum (`exception_code_t`) and `EXCEPTION_VECTOR` default belong in `coprocessor0_params`.
- Bus types stay in `wb_stage_params` and `coprocessor0_params`.
- Dispatcher state enum is local.
- One sub-module, `exception_priority_encoder`: purely combinational, mapping flags plus the interrupt bit to {valid, code, is_address_fault}.

## Test plan
- Plain ALU commit, pc 0xbfc00100 → bus all 0, no flush, `wb_ready` stays 1.
- Ov at pc 0xbfc00200 in a delay slot → code 0x0c, `exception_address` 0xbfc00200, `in_delay_slot` 1. N+1: flush 1, redirect 0xbfc00380. `redirect_ready` stalled 3 cycles → address held, then IDLE.
- Store to 0x80000003 with AdES → code 0x05, `badvaddr_value` 0x80000003, `is_address_fault` 1.
- `interrupt_valid` = 0x80 with ERET retiring next cycle → code 0x00, `eret_flush` 0, redirect 0xbfc00380. Without the macro: ERET to EPC.
- MTC0 EPC ← 0xbfc00400 then ERET → `write_enabled` 1 (reg 14, sel 0), then `eret_flush` 1 and redirect 0xbfc00400.
- Reset asserted in REDIRECT → next cycle `redirect_valid` 0, `wb_ready` 1, flush 0.
